// File: rtl/primus_pkg.sv
// primus_pkg: shared types and constants for the primus fetch path.
//   fetch_state_e : fetch sequencer states
//   fetch_entry_t : one buffered instruction together with its PC
//   ILEN, PC_INC  : instruction width and sequential PC step
package primus_pkg;

  localparam int unsigned ILEN   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/primus_fetch_fifo.sv
// primus_fetch_fifo: synchronous FIFO of fetch_entry_t.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   push_i/entry_i write one entry
//   pop_i          drop the head entry
//   flush_i        empty the FIFO; wins over a simultaneous push
//   head_o         head entry, read straight from the storage registers
//   count_o        number of valid entries
//   empty_o/full_o occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module primus_fetch_fifo
  import primus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  fetch_entry_t             entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [DEPTH-1:0] wr_en;

  // One write strobe per entry; a flush suppresses the push.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_wr_en
      assign wr_en[gi] = push_i && !flush_i && (wr_ptr_q == PW'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared at reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst_i)         mem_q[i] <= '0;
      else if (wr_en[i]) mem_q[i] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/primus_fetch_controller.sv
// primus_fetch_controller: instruction fetch sequencer for the primus core.
// Owns the fetch PC, issues one-outstanding req/gnt/rvalid transactions,
// buffers responses with their PC and hands them to decode (valid/ready).
// Redirects flush the buffer and discard any response still in flight.
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   fetch_en_i                  permit new requests
//   redirect_i, redirect_pc_i   PC redirect (bits [1:0] ignored)
//   imem_req_o/addr_o/gnt_i     request channel
//   imem_rvalid_i/rdata_i       response channel
//   ir_valid_o/ready_i/ir_o     decode interface, pc_o/npc_o head PC and PC+4
//   busy_o                      request or response outstanding
//   perf_fetch_cnt_o, perf_stall_cnt_o  counters, live only when the
//                               PRIMUS_FETCH_PERF_EN macro is defined
module primus_fetch_controller
  import primus_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_en_i,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  output logic            imem_req_o,
  output logic [31:0]     imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            ir_valid_o,
  input  logic            ir_ready_i,
  output logic [ILEN-1:0] ir_o,
  output logic [31:0]     pc_o,
  output logic [31:0]     npc_o,
  output logic            busy_o,
  output logic [31:0]     perf_fetch_cnt_o,
  output logic [31:0]     perf_stall_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         hold_q, hold_d;     // request asserted, waiting for gnt

  logic         push, pop, fifo_empty, fifo_full;
  logic [CW:0]  fifo_count;
  logic [CW+1:0] occupancy;
  logic         credit;
  fetch_entry_t push_entry, head;

  // Requests are only issued in FETCH where nothing is outstanding, so the
  // full flag and the occupancy rule agree; both are kept for clarity.
  assign occupancy = {1'b0, fifo_count} + (CW+2)'(state_q == WAIT);
  assign credit    = !fifo_full && (occupancy < (CW+2)'(FIFO_DEPTH));

  assign imem_req_o  = (state_q == FETCH) && (hold_q || (credit && fetch_en_i));
  assign imem_addr_o = imem_req_o ? fetch_pc_q : 32'h0;

  assign push       = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};
  assign ir_valid_o = !fifo_empty && !redirect_i;
  assign pop        = ir_valid_o && ir_ready_i;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    hold_d     = hold_q;
    case (state_q)
      IDLE:  if (fetch_en_i) state_d = FETCH;
      FETCH: begin
        if (imem_req_o && imem_gnt_i) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_INC;
          hold_d     = 1'b0;
          state_d    = WAIT;
        end else if (imem_req_o) begin
          hold_d = 1'b1;
        end else if (!fetch_en_i) begin
          state_d = IDLE;
        end
      end
      WAIT:  if (imem_rvalid_i) state_d = fetch_en_i ? FETCH : IDLE;
      FLUSH: if (imem_rvalid_i) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // A redirect overrides everything; a request already granted still owes
    // a response, which FLUSH absorbs.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ~32'h3;
      hold_d     = 1'b0;
      case (state_q)
        WAIT:    state_d = imem_rvalid_i ? FETCH : FLUSH;
        FLUSH:   state_d = imem_rvalid_i ? FETCH : FLUSH;
        FETCH:   state_d = (imem_req_o && imem_gnt_i) ? FLUSH : FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= BOOT_ADDR;
      req_pc_q   <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      hold_q     <= hold_d;
    end
  end

  primus_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign ir_o   = head.instr;
  assign pc_o   = head.pc;
  assign npc_o  = head.pc + PC_INC;
  assign busy_o = (state_q == WAIT) || (state_q == FLUSH) || imem_req_o;

`ifdef PRIMUS_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (push && (perf_fetch_q != 32'hFFFF_FFFF))
      perf_fetch_d = perf_fetch_q + 32'd1;
    if (ir_valid_o && !ir_ready_i && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  assign perf_fetch_cnt_o = 32'h0;
  assign perf_stall_cnt_o = 32'h0;
`endif

endmodule
